// File: rtl/icache_downstream_rsp_if.sv
// Downstream linefill channel between the icache (master) and its memory responder (slave).
// Carries the txreq request handshake and the full-line rxdat response handshake.
interface icache_downstream_rsp_if #(
  parameter int unsigned REQ_ADDR_WIDTH         = 32,
  parameter int unsigned MSHR_ENTRY_INDEX_WIDTH = 4,
  parameter int unsigned ICACHE_REQ_TXNID_WIDTH = 8,
  parameter int unsigned ICACHE_DATA_WIDTH      = 512,
  parameter int unsigned OPCODE_WIDTH           = 4
);
  typedef struct packed {
    logic [ICACHE_DATA_WIDTH-1:0]      data;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0] entry_idx;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
    logic [OPCODE_WIDTH-1:0]           opcode;
  } downstream_rxdat_t;

  logic                              downstream_txreq_vld;
  logic                              downstream_txreq_rdy;
  logic [REQ_ADDR_WIDTH-1:0]         downstream_txreq_addr;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] downstream_txreq_entry_idx;
  logic [ICACHE_REQ_TXNID_WIDTH-1:0] downstream_txreq_txnid;
  logic                              downstream_rxdat_vld;
  logic                              downstream_rxdat_rdy;
  downstream_rxdat_t                 downstream_rxdat_pld;

  modport master (
    output downstream_txreq_vld, downstream_txreq_addr, downstream_txreq_entry_idx,
           downstream_txreq_txnid, downstream_rxdat_rdy,
    input  downstream_txreq_rdy, downstream_rxdat_vld, downstream_rxdat_pld
  );

  modport slave (
    input  downstream_txreq_vld, downstream_txreq_addr, downstream_txreq_entry_idx,
           downstream_txreq_txnid, downstream_rxdat_rdy,
    output downstream_txreq_rdy, downstream_rxdat_vld, downstream_rxdat_pld
  );
endinterface

// File: rtl/icache_downstream_rsp.sv
// Linefill memory model: queues requests in order and returns a whole line LATENCY cycles later.
// Optional ICACHE_DS_RSP_PERF_EN adds request/response counters and a peak-occupancy tracker.
module icache_downstream_rsp #(
  parameter int unsigned DEPTH                  = 4,
  parameter int unsigned LATENCY                = 8,
  parameter int unsigned REQ_ADDR_WIDTH         = 32,
  parameter int unsigned MSHR_ENTRY_INDEX_WIDTH = 4,
  parameter int unsigned ICACHE_REQ_TXNID_WIDTH = 8,
  parameter int unsigned ICACHE_DATA_WIDTH      = 512,
  parameter int unsigned OPCODE_WIDTH           = 4,
  parameter logic [OPCODE_WIDTH-1:0] UPSTREAM_OPCODE = 4'h1
) (
  input logic                   clk,
  input logic                   rst_n,
  icache_downstream_rsp_if.slave ds
`ifdef ICACHE_DS_RSP_PERF_EN
  ,
  output logic [31:0]              perf_req_cnt,
  output logic [31:0]              perf_rsp_cnt,
  output logic [$clog2(DEPTH):0]   perf_max_occ
`endif
);
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned OFFS  = $clog2(ICACHE_DATA_WIDTH / 8);
  localparam int unsigned WORDS = ICACHE_DATA_WIDTH / 32;
  localparam int unsigned EXT_W = (REQ_ADDR_WIDTH > 32) ? REQ_ADDR_WIDTH : 32;
  // Loaded with LATENCY-1: the push edge itself accounts for the first cycle.
  localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [REQ_ADDR_WIDTH-1:0]         addr_q  [DEPTH];
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] idx_q   [DEPTH];
  logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid_q [DEPTH];
  logic [7:0]                        cnt_q   [DEPTH];
  logic [PW-1:0]                     wr_ptr_q, rd_ptr_q;
  logic [PW:0]                       count_q, count_d;
  logic                              full, push, pop, rsp_vld;
  logic [EXT_W-1:0]                  base_ext;
  logic [31:0]                       base32;
  logic [ICACHE_DATA_WIDTH-1:0]      line_data;

  assign full    = (count_q == FULL_CNT);
  assign push    = ds.downstream_txreq_vld && !full;
  assign rsp_vld = (count_q != '0) && (cnt_q[rd_ptr_q] == 8'd0);
  assign pop     = rsp_vld && ds.downstream_rxdat_rdy;

  assign ds.downstream_txreq_rdy = !full;
  assign ds.downstream_rxdat_vld = rsp_vld;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Countdowns run for every slot; empty slots already sit at zero, so an empty queue is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        idx_q[i]   <= '0;
        txnid_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr_q == PW'(i))) begin
          addr_q[i]  <= ds.downstream_txreq_addr;
          idx_q[i]   <= ds.downstream_txreq_entry_idx;
          txnid_q[i] <= ds.downstream_txreq_txnid;
          cnt_q[i]   <= CNT_INIT;
        end else if (cnt_q[i] != 8'd0) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    base_ext                       = '0;
    base_ext[REQ_ADDR_WIDTH-1:0]   = addr_q[rd_ptr_q];
    base_ext[OFFS-1:0]             = '0;
    base32                         = base_ext[31:0];
    line_data                      = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      line_data[i*32 +: 32] = base32 + 32'(i * 4);
    end
  end

  assign ds.downstream_rxdat_pld = rsp_vld
    ? {line_data, idx_q[rd_ptr_q], txnid_q[rd_ptr_q], UPSTREAM_OPCODE}
    : '0;

`ifdef ICACHE_DS_RSP_PERF_EN
  logic [31:0] perf_req_cnt_q, perf_rsp_cnt_q;
  logic [PW:0] perf_max_occ_q, occ_now;

  // Occupancy includes the entry being pushed this cycle.
  assign occ_now = count_q + (PW + 1)'(push);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_req_cnt_q <= '0;
      perf_rsp_cnt_q <= '0;
      perf_max_occ_q <= '0;
    end else begin
      if (push) perf_req_cnt_q <= perf_req_cnt_q + 32'd1;
      if (pop)  perf_rsp_cnt_q <= perf_rsp_cnt_q + 32'd1;
      if (occ_now > perf_max_occ_q) perf_max_occ_q <= occ_now;
    end
  end

  assign perf_req_cnt = perf_req_cnt_q;
  assign perf_rsp_cnt = perf_rsp_cnt_q;
  assign perf_max_occ = perf_max_occ_q;
`endif
endmodule

// File: doc/icache_downstream_rsp.md
Name: icache_downstream_rsp

Overview:
- Downstream-side linefill responder for the icache; it is the far end of the downstream rxdat interface.
- Accepts linefill requests carrying address, MSHR entry index and txnid, and buffers them in an in-order queue.
- After a fixed latency it returns one full cacheline on downstream_rxdat using valid/ready handshake.
- Serves as the memory model for icache block and subsystem benches; data is a deterministic function of address.

Parameters:
- DEPTH, 4, request queue entries (power of 2, >=2).
- LATENCY, 8, cycles from request accept to first rxdat_vld (>=1, <=255).
- REQ_ADDR_WIDTH, 32, linefill request address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- downstream_txreq_vld  in  1  linefill request valid.
- downstream_txreq_rdy  out  1  request ready.
- downstream_txreq_addr  in  REQ_ADDR_WIDTH  request byte address.
- downstream_txreq_entry_idx  in  MSHR_ENTRY_INDEX_WIDTH  requesting MSHR entry.
- downstream_txreq_txnid  in  ICACHE_REQ_TXNID_WIDTH  upstream txnid.
- downstream_rxdat_vld  out  1  response valid.
- downstream_rxdat_rdy  in  1  response ready.
- downstream_rxdat_pld  out  downstream_rxdat_t  fields: data, entry_idx, txnid, opcode.

Behaviour:
- Reset: queue empty, downstream_rxdat_vld=0, downstream_txreq_rdy=1, pld all zero. Reset mid-operation drops all queued requests; no response is issued after reset release for pre-reset requests.
- Accept: a request is accepted on a cycle with txreq_vld && txreq_rdy. txreq_rdy = !full; there is no same-cycle bypass of a pop into a full queue.
- Queue entry stores addr, entry_idx, txnid and an 8-bit countdown loaded at push. Countdown decrements every cycle, saturates at 0, and runs for all entries in parallel, so latencies overlap.
- Response timing: head entry is ready when its countdown is 0. If head is accepted in cycle T and the output is free, rxdat_vld first asserts in cycle T+LATENCY.
- Ordering: responses leave in strict acceptance order; a younger entry never overtakes the head.
- Handshake: once rxdat_vld=1, vld and pld hold stable until a cycle with rxdat_vld && rxdat_rdy. The consumer may assert rdy one or more cycles after vld. The head pops on the handshake cycle.
- Back-to-back: the next ready head may assert vld in the cycle after the handshake (one response per cycle max).
- Payload: entry_idx and txnid are copied from the request. opcode = UPSTREAM_OPCODE.
- Data: line base = addr with low log2(ICACHE_DATA_WIDTH/8) bits cleared. 32-bit word i (i = 0 .. ICACHE_DATA_WIDTH/32-1, word 0 at bits [31:0]) = base + 4*i, truncated/zero-extended to 32 bits.
- pld is 0 whenever vld=0.
- Full: with DEPTH entries queued, rdy=0. Simultaneous push and pop are only possible when not full; occupancy is then unchanged.
- Empty: vld=0 and countdown logic is idle.

Optional Feature:
- Macro ICACHE_DS_RSP_PERF_EN.
- Defined: adds outputs perf_req_cnt (32b, accepted requests), perf_rsp_cnt (32b, completed handshakes) and perf_max_occ (log2(DEPTH)+1 b, peak occupancy). Counters are reset to 0 by rst_n and wrap at 2^32. Occupancy counts the entry at its push cycle.
- Undefined: these ports and counters do not exist; functional behaviour is identical.

Test Plan:
- Single request, addr=0x1000, entry_idx=2, txnid=5, accepted at cycle T, rxdat_rdy tied 1 -> vld at T+8 for exactly 1 cycle; data word0=0x1000, word15=0x103C; entry_idx=2, txnid=5.
- Unaligned addr=0x2024 -> data word0=0x2000, word15=0x203C.
- Five back-to-back requests with rxdat_rdy=0 -> rdy drops after the 4th accept; the 5th is held until the first pop. Then, with rdy=1, four responses arrive on consecutive cycles in order.
- Consumer asserts rdy 1 cycle after vld (registered-ready style) -> vld and pld stable across the stall; exactly one handshake per request; no duplicates.
- Assert rst_n=0 with 3 requests queued -> vld=0 and txreq_rdy=1 after reset; no stale responses over 20 cycles.
- With ICACHE_DS_RSP_PERF_EN, 6 requests at peak occupancy 3 -> perf_req_cnt=6, perf_rsp_cnt=6, perf_max_occ=3.
